ipsl_pcie_cfg_rsp: RTL
======================

# ipsl_pcie_cfg_rsp

Configuration-space completer for the PCIe endpoint path. It is the responder for the Configuration Read/Write TLPs that the config requester issues. It receives single-DW CfgRd/CfgWr requests on the core's AXIS master (RX) stream and performs the access on a local 1-DW register port. It then returns a Cpl/CplD on the core's AXIS slave (TX) stream. It sits on a dedicated RX stream that has already been filtered to configuration traffic, in the `pclk_div2` domain.

## Interface
- No parameters.
- `pclk_div2`  in  1  block clock
- `apb_rst`  in  1  synchronous active-high reset
- `axis_master_tvalid`  in  1  RX TLP beat valid
- `axis_master_tready`  out  1  RX beat accept
- `axis_master_tlast`  in  1  RX last beat
- `axis_master_tkeep`  in  4  RX DW enables
- `axis_master_tdata`  in  128  RX beat; DW0 = tdata[31:0]
- `axis_slave_tvalid`  out  1  completion valid
- `axis_slave_tready`  in  1  core accepts completion
- `axis_slave_tlast`  out  1  completion last
- `axis_slave_tuser`  out  1  tied 0
- `axis_slave_tdata`  out  128  completion TLP
- `reg_req`  out  1  one-cycle register access strobe
- `reg_we`  out  1  1 = write
- `reg_addr`  out  10  {ext reg[3:0], reg num[5:0]}
- `reg_be`  out  4  first DW BE
- `reg_wdata`  out  32  write data
- `reg_rdata`  in  32  read data, valid the cycle after `reg_req`
- `tlp_drop`  out  1  one-cycle pulse per discarded TLP

## Operation
- Request header decode:
  - DW0: fmt[31:29], type[28:24], length[9:0].
  - DW1: req ID[31:16], tag[15:8], last BE[7:4], first BE[3:0].
  - DW2: bus/dev/fn[31:16], ext reg[11:8], reg num[7:2].
  - DW3: write data.
- Request classification:
  - CfgRd0: fmt=000, type=00100.
  - CfgWr0: fmt=010, type=00100.
  - Type1 (type=00101): UR unless enabled (see Configuration).
  - Other fmt/type: drop.
- Malformed requests (length≠1, last BE≠0, or CfgWr with tkeep≠4'hF) get a UR completion. No register access is made.
- A first beat without tlast is dropped: enter DROP and consume beats through tlast. `tlp_drop` pulses on the first beat.
- FSM states:
  - IDLE: tready=1. Capture the header on handshake. Go to REG for a valid cfg request, CPL for UR, DROP for a multi-beat or unknown TLP.
  - DROP: tready=1. Return to IDLE after the tlast beat.
  - REG: `reg_req`=1 for one cycle. Reads go to RDW. Writes go to CPL.
  - RDW: capture `reg_rdata`, then CPL.
  - CPL: `axis_slave_tvalid`=1 and tlast=1. Go to IDLE on tready.
- `axis_master_tready`=0 in REG, RDW and CPL.
- CfgWr with first BE=0 still issues `reg_req` with `reg_be`=0.
- Completion, single beat:
  - DW0: fmt=010 (CplD, reads, length=1) or 000 (Cpl, writes and UR, length=0); type=01010; TC/attr=0.
  - DW1: completer ID = request bus/dev/fn [31:16]; status [15:13] = 000 SC or 001 UR; BCM=0; byte count[11:0]=4.
  - DW2: req ID[31:16], tag[15:8], lower addr[6:0]=0.
  - DW3: read data for reads, 0 otherwise.

## Timing
- Reset values: tvalid=0, tlast=0, tuser=0, tdata=0, tready=0 during reset and 1 in the first cycle after reset, reg_req=0, reg_we=0, reg_addr=0, reg_be=0, reg_wdata=0, tlp_drop=0; FSM in IDLE.
- With request handshake in cycle N:
  - CfgRd: reg_req at N+1, tvalid from N+3.
  - CfgWr: reg_req at N+1, tvalid from N+2.
  - UR: tvalid from N+1.
- tdata and tlast stay stable while tvalid=1 and tready=0. tvalid is not withdrawn.
- On a completion handshake in cycle M, tready=1 at M+1.
- At most one outstanding request; back-to-back requests are throttled by tready.
- Reset asserted mid-transaction aborts it: no completion and no further reg_req. Outputs return to their reset values on the next clock edge.

## Configuration
- `IPSL_PCIE_CFG_RSP_TYPE1_EN`:
  - Defined: CfgRd1/CfgWr1 are handled exactly like Type0 (register access plus SC completion).
  - Undefined: Type1 requests get a UR Cpl with no register access.

## Test plan
- CfgRd0 with reg num=0x04, ext=0, first BE=F, tag=0x12, req ID=0x0100, reg_rdata=0xDEADBEEF -> reg_req at N+1 with reg_addr=0x004 and reg_we=0; CplD at N+3 with status 000, tag 0x12, DW3=0xDEADBEEF.
- CfgWr0 with data 0x1234_5678 and first BE=0x3 -> reg_we=1, reg_be=0x3, reg_wdata=0x12345678; Cpl at N+2 with length 0 and status SC.
- CfgRd1 with macro undefined -> no reg_req; Cpl at N+1 with status 001. With macro defined -> behaves as the CfgRd0 case.
- 3-beat MWr TLP -> tlp_drop pulses once; all 3 beats accepted; no completion; next CfgRd is served normally.
- Completion held with axis_slave_tready=0 for 5 cycles -> tdata stable, tvalid held, axis_master_tready=0 throughout; IDLE one cycle after acceptance.
- apb_rst asserted at N+2 of a CfgRd -> tvalid never asserted; all outputs at reset values.

Source files
------------

// File: rtl/ipsl_pcie_cfg_rsp_if.sv
// AXIS stream pair between the PCIe core and the configuration completer.
// The completer takes the slave view: RX TLPs come in, completions go out.
interface ipsl_pcie_cfg_rsp_if;
   logic         axis_master_tvalid;
   logic         axis_master_tready;
   logic         axis_master_tlast;
   logic [3:0]   axis_master_tkeep;
   logic [127:0] axis_master_tdata;
   logic         axis_slave_tvalid;
   logic         axis_slave_tready;
   logic         axis_slave_tlast;
   logic         axis_slave_tuser;
   logic [127:0] axis_slave_tdata;

   modport master (
      output axis_master_tvalid, axis_master_tlast, axis_master_tkeep, axis_master_tdata,
      input  axis_master_tready,
      input  axis_slave_tvalid, axis_slave_tlast, axis_slave_tuser, axis_slave_tdata,
      output axis_slave_tready
   );

   modport slave (
      input  axis_master_tvalid, axis_master_tlast, axis_master_tkeep, axis_master_tdata,
      output axis_master_tready,
      output axis_slave_tvalid, axis_slave_tlast, axis_slave_tuser, axis_slave_tdata,
      input  axis_slave_tready
   );
endinterface

// File: rtl/ipsl_pcie_cfg_rsp.sv
// Configuration-space completer: single-DW CfgRd/CfgWr in, local register access, Cpl/CplD out.
// Define IPSL_PCIE_CFG_RSP_TYPE1_EN to serve Type1 config requests like Type0.
module ipsl_pcie_cfg_rsp (
   input  logic                      pclk_div2,
   input  logic                      apb_rst,
   ipsl_pcie_cfg_rsp_if.slave        axis,
   output logic                      reg_req,
   output logic                      reg_we,
   output logic [9:0]                reg_addr,
   output logic [3:0]                reg_be,
   output logic [31:0]               reg_wdata,
   input  logic [31:0]               reg_rdata,
   output logic                      tlp_drop
);

   // state  | meaning
   // IDLE   | ready for a request header beat
   // DROP   | swallowing beats of a discarded TLP up to tlast
   // REG    | reg_req strobe cycle
   // RDW    | register read data being captured
   // CPL    | completion presented, waiting for core tready
   typedef enum logic [2:0] {
      S_IDLE,
      S_DROP,
      S_REG,
      S_RDW,
      S_CPL
   } state_t;

`ifdef IPSL_PCIE_CFG_RSP_TYPE1_EN
   localparam logic TYPE1_EN = 1'b1;
`else
   localparam logic TYPE1_EN = 1'b0;
`endif

   state_t state;
   logic   rd_q;

   logic [31:0] dw0, dw1, dw2, dw3;
   logic        fmt_rd, fmt_wr, typ_t0, typ_t1;
   logic        is_cfg, malformed, is_ur, rx_hs;
   logic [31:0] cpl_dw0, cpl_dw1, cpl_dw2;
   logic        unused_hdr;

   assign dw0 = axis.axis_master_tdata[31:0];
   assign dw1 = axis.axis_master_tdata[63:32];
   assign dw2 = axis.axis_master_tdata[95:64];
   assign dw3 = axis.axis_master_tdata[127:96];

   assign fmt_rd    = (dw0[31:29] == 3'b000);
   assign fmt_wr    = (dw0[31:29] == 3'b010);
   assign typ_t0    = (dw0[28:24] == 5'b00100);
   assign typ_t1    = (dw0[28:24] == 5'b00101);
   assign is_cfg    = (fmt_rd | fmt_wr) & (typ_t0 | typ_t1);
   assign malformed = (dw0[9:0] != 10'd1) | (dw1[7:4] != 4'h0)
                    | (fmt_wr & (axis.axis_master_tkeep != 4'hF));
   assign is_ur     = malformed | (typ_t1 & ~TYPE1_EN);
   assign rx_hs     = axis.axis_master_tvalid & axis.axis_master_tready;

   // Writes and UR complete without data; only a good read returns CplD.
   assign cpl_dw0 = (is_ur | fmt_wr) ? 32'h0A00_0000 : 32'h4A00_0001;
   assign cpl_dw1 = {dw2[31:16], (is_ur ? 3'b001 : 3'b000), 1'b0, 12'd4};
   assign cpl_dw2 = {dw1[31:16], dw1[15:8], 8'h00};

   assign unused_hdr = ^{dw0[23:10], dw2[15:12], dw2[1:0]};

   assign axis.axis_slave_tuser = 1'b0;

   always_ff @(posedge pclk_div2) begin
      if (apb_rst) begin
         state                   <= S_IDLE;
         rd_q                    <= 1'b0;
         axis.axis_master_tready <= 1'b0;
         axis.axis_slave_tvalid  <= 1'b0;
         axis.axis_slave_tlast   <= 1'b0;
         axis.axis_slave_tdata   <= '0;
         reg_req                 <= 1'b0;
         reg_we                  <= 1'b0;
         reg_addr                <= '0;
         reg_be                  <= '0;
         reg_wdata               <= '0;
         tlp_drop                <= 1'b0;
      end else begin
         reg_req  <= 1'b0;
         tlp_drop <= 1'b0;
         case (state)
            S_IDLE: begin
               axis.axis_master_tready <= 1'b1;
               if (rx_hs) begin
                  if (!axis.axis_master_tlast) begin
                     tlp_drop <= 1'b1;
                     state    <= S_DROP;
                  end else if (!is_cfg) begin
                     tlp_drop <= 1'b1;
                  end else begin
                     axis.axis_master_tready <= 1'b0;
                     axis.axis_slave_tdata   <= {32'h0, cpl_dw2, cpl_dw1, cpl_dw0};
                     rd_q                    <= fmt_rd;
                     if (is_ur) begin
                        axis.axis_slave_tvalid <= 1'b1;
                        axis.axis_slave_tlast  <= 1'b1;
                        state                  <= S_CPL;
                     end else begin
                        reg_req   <= 1'b1;
                        reg_we    <= fmt_wr;
                        reg_addr  <= {dw2[11:8], dw2[7:2]};
                        reg_be    <= dw1[3:0];
                        reg_wdata <= dw3;
                        state     <= S_REG;
                     end
                  end
               end
            end
            S_DROP: begin
               if (rx_hs && axis.axis_master_tlast) state <= S_IDLE;
            end
            S_REG: begin
               if (rd_q) begin
                  state <= S_RDW;
               end else begin
                  axis.axis_slave_tvalid <= 1'b1;
                  axis.axis_slave_tlast  <= 1'b1;
                  state                  <= S_CPL;
               end
            end
            S_RDW: begin
               axis.axis_slave_tdata[127:96] <= reg_rdata;
               axis.axis_slave_tvalid        <= 1'b1;
               axis.axis_slave_tlast         <= 1'b1;
               state                         <= S_CPL;
            end
            S_CPL: begin
               if (axis.axis_slave_tready) begin
                  axis.axis_slave_tvalid  <= 1'b0;
                  axis.axis_slave_tlast   <= 1'b0;
                  axis.axis_master_tready <= 1'b1;
                  state                   <= S_IDLE;
               end
            end
            default: begin
               axis.axis_master_tready <= 1'b1;
               state                   <= S_IDLE;
            end
         endcase
      end
   end

endmodule
